// File: rtl/reservation_station.sv
// Single-issue reservation station: compacting queue (slot 0 oldest) that wakes operands
// from the result ring and issues the oldest fully-ready uop over a valid/ready handshake.
module reservation_station #(
  parameter int unsigned NUM_ENTRIES   = 8,
  parameter int unsigned PHYSFILE_SIZE = 128,
  parameter int unsigned REG_SIZE      = 32,
  parameter int unsigned OP_WIDTH      = 8,
  localparam int unsigned TAGW = $clog2(PHYSFILE_SIZE),
  localparam int unsigned CNTW = $clog2(NUM_ENTRIES + 1),
  localparam int unsigned IDXW = $clog2(NUM_ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  output logic                alloc_ready,
  input  logic [OP_WIDTH-1:0] alloc_op,
  input  logic [TAGW-1:0]     alloc_rs1_tag,
  input  logic                alloc_rs1_rdy,
  input  logic [REG_SIZE-1:0] alloc_rs1_val,
  input  logic [TAGW-1:0]     alloc_rs2_tag,
  input  logic                alloc_rs2_rdy,
  input  logic [REG_SIZE-1:0] alloc_rs2_val,
  input  logic [TAGW-1:0]     alloc_wr_tag,
  input  logic                ring_update,
  input  logic [TAGW-1:0]     phys_ring,
  input  logic [REG_SIZE-1:0] phys_ring_val,
  input  logic                rollback,
  output logic                issue_valid,
  input  logic                issue_ready,
  output logic [OP_WIDTH-1:0] issue_op,
  output logic [REG_SIZE-1:0] issue_rs1_val,
  output logic [REG_SIZE-1:0] issue_rs2_val,
  output logic [TAGW-1:0]     issue_wr_tag,
  output logic [CNTW-1:0]     occupancy
);

  typedef struct packed {
    logic                valid;
    logic [OP_WIDTH-1:0] op;
    logic [TAGW-1:0]     rs1_tag;
    logic                rs1_rdy;
    logic [REG_SIZE-1:0] rs1_val;
    logic [TAGW-1:0]     rs2_tag;
    logic                rs2_rdy;
    logic [REG_SIZE-1:0] rs2_val;
    logic [TAGW-1:0]     wr_tag;
  } entry_t;

  entry_t          slot_q [NUM_ENTRIES];
  entry_t          slot_d [NUM_ENTRIES];
  entry_t          woke   [NUM_ENTRIES];
  entry_t          new_entry;
  logic [CNTW-1:0] count_q, count_d;
  logic [CNTW-1:0] alloc_pos;
  logic [IDXW-1:0] sel_idx;
  logic            sel_found;
  logic            alloc_fire, issue_fire;

  assign alloc_ready = (count_q < CNTW'(NUM_ENTRIES));
  assign occupancy   = count_q;
  assign issue_valid = !rollback && sel_found;
  assign issue_fire  = issue_valid && issue_ready;
  assign alloc_fire  = alloc_valid && alloc_ready && !rollback;
  // After an issue the queue compacts first, so the new uop lands one slot lower.
  assign alloc_pos   = count_q - CNTW'(issue_fire);

  // Oldest-first select: scan downward so the lowest eligible index wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (slot_q[i].valid && slot_q[i].rs1_rdy && slot_q[i].rs2_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IDXW'(i);
      end
    end
  end

  always_comb begin
    issue_op      = '0;
    issue_rs1_val = '0;
    issue_rs2_val = '0;
    issue_wr_tag  = '0;
    if (issue_valid) begin
      issue_op      = slot_q[sel_idx].op;
      issue_rs1_val = slot_q[sel_idx].rs1_val;
      issue_rs2_val = slot_q[sel_idx].rs2_val;
      issue_wr_tag  = slot_q[sel_idx].wr_tag;
    end
  end

  always_comb begin
    // Incoming uop, with same-cycle ring bypass for operands still waiting.
    new_entry         = '0;
    new_entry.valid   = 1'b1;
    new_entry.op      = alloc_op;
    new_entry.wr_tag  = alloc_wr_tag;
    new_entry.rs1_tag = alloc_rs1_tag;
    new_entry.rs1_rdy = alloc_rs1_rdy;
    new_entry.rs1_val = alloc_rs1_val;
    new_entry.rs2_tag = alloc_rs2_tag;
    new_entry.rs2_rdy = alloc_rs2_rdy;
    new_entry.rs2_val = alloc_rs2_val;
    if (ring_update && !alloc_rs1_rdy && alloc_rs1_tag == phys_ring) begin
      new_entry.rs1_rdy = 1'b1;
      new_entry.rs1_val = phys_ring_val;
    end
    if (ring_update && !alloc_rs2_rdy && alloc_rs2_tag == phys_ring) begin
      new_entry.rs2_rdy = 1'b1;
      new_entry.rs2_val = phys_ring_val;
    end

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      woke[i] = slot_q[i];
      if (ring_update && slot_q[i].valid && !slot_q[i].rs1_rdy &&
          slot_q[i].rs1_tag == phys_ring) begin
        woke[i].rs1_rdy = 1'b1;
        woke[i].rs1_val = phys_ring_val;
      end
      if (ring_update && slot_q[i].valid && !slot_q[i].rs2_rdy &&
          slot_q[i].rs2_tag == phys_ring) begin
        woke[i].rs2_rdy = 1'b1;
        woke[i].rs2_val = phys_ring_val;
      end
    end

    for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
      slot_d[i] = (issue_fire && IDXW'(i) >= sel_idx) ? woke[i+1] : woke[i];
    end
    slot_d[NUM_ENTRIES-1] = issue_fire ? '0 : woke[NUM_ENTRIES-1];

    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (alloc_fire && CNTW'(i) == alloc_pos) begin
        slot_d[i] = new_entry;
      end
      if (rollback) begin
        slot_d[i] = '0;
      end
    end

    count_d = rollback ? '0 : count_q + CNTW'(alloc_fire) - CNTW'(issue_fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        slot_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        slot_q[i] <= slot_d[i];
      end
      count_q <= count_d;
    end
  end

endmodule
